// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, decoder codes and buffer layout for the 8-digit
// time-multiplexed 7-segment scan driver.
package seg7_scan_driver_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low g..a patterns for hex digits 0..F.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  point;
    logic [7:0]  blank;
  } disp_buf_t;

  function automatic logic [7:0] digit_enable(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational 4-bit hex nibble to active-low 7-segment (g..a) decoder.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered 8-digit common-anode scan driver: a loaded word is swapped
// into the active buffer only on the digit 7 -> 0 wrap, so frames never tear.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_CYCLES = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blank_in,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  // Handshake: load is a single-cycle strobe with no ready/backpressure; the
  // word is always accepted, and a later load in the same frame overwrites it.

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  disp_buf_t        staging;
  disp_buf_t        active;
  disp_buf_t        in_buf;
  logic             pending;
  logic             tc;
  logic             wrap;
  logic [3:0]       nib;
  logic [6:0]       dec_seg;

  assign in_buf = {data_in, point_in, blank_in};
  assign tc     = (cnt == CNT_W'(SCAN_CYCLES - 1));
  assign wrap   = tc && (idx == LAST_DIGIT);
  assign nib    = active.data[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      staging    <= '0;
      active     <= '0;
      pending    <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      if (tc) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      frame_done <= wrap;

      if (load) staging <= in_buf;

      // A load landing exactly on the wrap goes straight to the display so it
      // does not wait a whole extra frame.
      if (wrap && load) begin
        active  <= in_buf;
        pending <= 1'b0;
      end else if (wrap && pending) begin
        active  <= staging;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      if (active.blank[idx]) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end else begin
        an  <= digit_enable(idx);
        seg <= {~active.point[idx], dec_seg};
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a short scan period.
module tb_seg7_scan_driver;

  localparam int SC    = 4;
  localparam int FRAME = 8 * SC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  point_in = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_CYCLES(SC), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .point_in   (point_in),
    .blank_in   (blank_in),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int fd_seen = 0;

  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic [6:0]  lut[16];

  // Reference model: t counts edges since reset release.
  int          t = 0;
  logic [31:0] m_data, s_data;
  logic [7:0]  m_point, m_blank, s_point, s_blank;
  logic        m_pend;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  point;
    logic [7:0]  blank;
    logic [7:0]  exp_seg0;
    logic [7:0]  exp_an0;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if ({an, seg, frame_done} !== mon_e) begin
        n_err++;
        $display("FAIL scan_t%0d: got an=%h seg=%h fd=%b expected an=%h seg=%h fd=%b",
                 t, an, seg, frame_done, mon_e[16:9], mon_e[8:1], mon_e[0]);
      end
    end
  end

  task automatic cycle(input logic r, input logic ld, input logic [31:0] d,
                       input logic [7:0] p, input logic [7:0] b);
    int          slot;
    logic        wrap;
    logic [31:0] tmp;
    logic [3:0]  nib;
    logic [7:0]  e_an, e_seg;
    rst = r; load = ld; data_in = d; point_in = p; blank_in = b;
    if (r) begin
      exp_q.push_back({8'hFF, 8'hFF, 1'b0});
      t = 0; m_pend = 1'b0;
      m_data = '0; m_point = '0; m_blank = '0;
      s_data = '0; s_point = '0; s_blank = '0;
    end else begin
      slot = (t / SC) % 8;
      wrap = ((t % FRAME) == FRAME - 1);
      tmp  = m_data >> (4 * slot);
      nib  = tmp[3:0];
      if (m_blank[slot]) begin
        e_an = 8'hFF; e_seg = 8'hFF;
      end else begin
        e_an = ~(8'h01 << slot);
        e_seg = {~m_point[slot], lut[nib]};
      end
      exp_q.push_back({e_an, e_seg, wrap});
      if (ld && wrap) begin
        m_data = d; m_point = p; m_blank = b; m_pend = 1'b0;
      end else if (wrap && m_pend) begin
        m_data = s_data; m_point = s_point; m_blank = s_blank; m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      if (ld) begin
        s_data = d; s_point = p; s_blank = b;
      end
      t++;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  task automatic ld_word(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    cycle(1'b0, 1'b1, d, p, b);
  endtask

  // Advance until the next cycle() call is the wrap edge.
  task automatic run_to_wrap();
    while ((t % FRAME) != FRAME - 1) idle();
  endtask

  task automatic run_to_phase(input int ph);
    while ((t % FRAME) != ph) idle();
  endtask

  initial begin
    int fd0;
    int last_pulse;
    int gap;
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{32'h76543210, 8'h00, 8'h00, 8'hC0, 8'hFE};
    vecs[1] = '{32'hFEDCBA98, 8'h00, 8'h00, 8'h80, 8'hFE};
    vecs[2] = '{32'h89ABCDEF, 8'hFF, 8'h00, 8'h0E, 8'hFE};
    vecs[3] = '{32'h00000001, 8'h01, 8'h80, 8'h79, 8'hFE};
    vecs[4] = '{32'h0000000A, 8'h00, 8'h01, 8'hFF, 8'hFF};
    vecs[5] = '{32'hC0FFEE5A, 8'h10, 8'h00, 8'h88, 8'hFE};

    // Reset and first digit after release
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_fd", frame_done, 1'b0);
    idle();
    chk("rel_an", an, 8'hFE);
    chk("rel_seg", seg, 8'hC0);

    // Mid-frame load, visible only after the wrap
    while (t < 10) idle();
    ld_word(32'h89ABCDEF, 8'h00, 8'h00);
    chk("old_word_seg", seg, 8'hC0);
    run_to_wrap();
    idle();
    chk("wrap_fd", frame_done, 1'b1);
    idle();
    chk("new_d0_an", an, 8'hFE);
    chk("new_d0_seg", seg, 8'h8E);
    chk("fd_one_cycle", frame_done, 1'b0);
    repeat (4) idle();
    chk("new_d1_an", an, 8'hFD);
    chk("new_d1_seg", seg, 8'h86);
    last_pulse = -1;
    gap = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      if (frame_done === 1'b1) begin
        if (last_pulse >= 0) gap = t - last_pulse;
        last_pulse = t;
      end
    end
    chk("frame_period", gap, FRAME);

    // Decimal point on digit 0, digit 7 blanked
    ld_word(32'h00000001, 8'h01, 8'h80);
    run_to_wrap();
    idle();
    idle();
    chk("dp_d0_seg", seg, 8'h79);
    run_to_phase(28);
    idle();
    chk("blank_d7_an", an, 8'hFF);
    chk("blank_d7_seg", seg, 8'hFF);

    // Two loads in one frame: last wins, one pulse
    run_to_phase(5);
    fd0 = fd_seen;
    ld_word(32'h11111111, 8'h00, 8'h00);
    repeat (3) idle();
    ld_word(32'h22222222, 8'h00, 8'h00);
    run_to_wrap();
    idle();
    idle();
    chk("last_load_seg", seg, 8'hA4);
    chk("single_pulse", fd_seen - fd0, 1);

    // Load exactly on the wrap edge
    run_to_wrap();
    ld_word(32'h0000000A, 8'h00, 8'h00);
    chk("bypass_fd", frame_done, 1'b1);
    idle();
    chk("bypass_seg", seg, 8'h88);
    run_to_wrap();
    idle();
    idle();
    chk("bypass_hold_seg", seg, 8'h88);

    // Reset with a pending load at digit 5
    run_to_phase(21);
    ld_word(32'h12345678, 8'hFF, 8'h00);
    cycle(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_fd", frame_done, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    idle();
    chk("postrst_an", an, 8'hFE);
    chk("postrst_seg", seg, 8'hC0);
    run_to_wrap();
    idle();
    idle();
    chk("discard_seg", seg, 8'hC0);

    // Table-driven decoder / point / blank sweep
    for (int v = 0; v < 6; v++) begin
      ld_word(vecs[v].data, vecs[v].point, vecs[v].blank);
      run_to_wrap();
      idle();
      idle();
      chk($sformatf("vec%0d_seg0", v), seg, vecs[v].exp_seg0);
      chk($sformatf("vec%0d_an0", v), an, vecs[v].exp_an0);
      run_to_wrap();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
